cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32I core. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the register file write enable, IR/PC load strobes, ALU/mux selects and the instruction/data memory request handshakes. Supports free-run and single-step operation. Halts on ECALL or an illegal opcode.

Parameters:
RESET_RUN, 0, 1 = leave reset directly into FETCH without needing run/step.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
run  in  1  level; execute continuously while high
step  in  1  pulse; execute exactly one instruction from IDLE
opcode  in  7  ir[6:0] from the instruction register
branch_taken  in  1  ALU branch-compare result, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  load the instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (qualified by dmem_req)
reg_write  out  1  register file write enable (RegWrite)
wb_sel  out  2  00 ALU, 01 MEM, 10 PC+4
alu_src  out  1  0 = rs2, 1 = imm32
alu_op  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct
pc_we  out  1  PC load
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 rs1+imm
state  out  3  current state encoding
retire  out  1  one-cycle pulse on instruction completion
halted  out  1  sticky halt flag
illegal  out  1  sticky, set when halt is caused by an illegal opcode

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unreachable and recovers to IDLE.
- Reset (rst=0, asynchronous): state=IDLE (FETCH if RESET_RUN=1). All outputs 0, including halted and illegal.
- IDLE: go to FETCH if run=1 or step=1. Otherwise hold.
- FETCH: imem_req=1 until imem_ready. In the imem_ready cycle, ir_we=1 (combinational with imem_ready) and go to DECODE. With zero wait, FETCH lasts 1 cycle.
- DECODE: all strobes 0.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 → EXEC.
  - 1110011 → HALT.
  - Any other opcode → HALT with illegal=1.
- EXEC, by instruction class:
  - R: alu_src=0, alu_op=10 → WB.
  - I: alu_src=1, alu_op=11 → WB.
  - load/store: alu_src=1, alu_op=00 → MEM.
  - branch: alu_src=0, alu_op=01, pc_we=1, pc_sel=branch_taken?01:00, retire=1 → boundary.
  - jal/jalr: alu_op=00 → WB.
- MEM: dmem_req=1 held until dmem_ready; dmem_we=1 for store only. On dmem_ready:
  - store: pc_we=1, pc_sel=00, retire=1 → boundary.
  - load: → WB.
- WB: exactly one cycle.
  - reg_write=1, retire=1, pc_we=1.
  - wb_sel: ALU for R/I, MEM for load, PC+4 for jal/jalr.
  - pc_sel: 01 for jal, 10 for jalr, else 00.
- Boundary: go to FETCH if run=1, otherwise IDLE. step is ignored outside IDLE, so a step pulse yields exactly one retirement.
- HALT: all strobes 0, halted=1. Left only by reset.
- reg_write is never asserted for store or branch. rd=x0 suppression is the register file's job.
- imem_ready/dmem_ready outside FETCH/MEM are ignored.
- Dropping run mid-instruction does not abort; the instruction completes, then the controller goes to IDLE.
- Reset asserted mid-MEM drops dmem_req immediately (asynchronously).
- Latency, zero-wait memories:
  - R/I/jal/jalr: 4 cycles.
  - load: 5 cycles.
  - store and branch: 4 and 3 cycles respectively.

Optional Feature:
STEP_PERF_CNT_EN
- Defined: adds output instret[31:0]. Reset 0, increments on every retire pulse, wraps 0xFFFFFFFF→0. Not incremented in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then run=1, opcode=0110011, zero-wait imem → state 0→1→2→3→5→1. reg_write=1 only in WB with wb_sel=00. retire pulses every 4 cycles.
- Load, dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0. Then WB with wb_sel=01, pc_sel=00. Total 8 cycles.
- Branch, branch_taken=1 then 0 → EXEC pc_we=1 with pc_sel=01 then 00. reg_write never 1. 3 cycles each.
- run=0, step pulsed once with jal → exactly one retire; wb_sel=10, pc_sel=01; returns to IDLE and stays there 10 cycles.
- opcode=0000000 → HALT, halted=1, illegal=1. run/step ignored for 20 cycles. rst low clears both asynchronously.
- rst asserted mid-MEM store → dmem_req=0 and state=0 before the next clk edge. With STEP_PERF_CNT_EN, instret=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core; 3-5 cycles per instruction with zero-wait memories,
// stalls in FETCH/MEM until imem_ready/dmem_ready. `define STEP_PERF_CNT_EN adds the instret retirement counter.
module cpu_step_ctrl #(
  parameter bit RESET_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [2:0] state,
  output logic       retire,
  output logic       halted,
  output logic       illegal
`ifdef STEP_PERF_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } cls_t;

  state_t cur, nxt;
  cls_t   cls, dec_cls;
  logic   dec_legal, dec_ecall;

  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    dec_ecall = 1'b0;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1110011: begin
        dec_legal = 1'b0;
        dec_ecall = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // Class is latched in DECODE so later stages do not depend on the IR holding still.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (RESET_RUN) cur <= S_FETCH;
      else           cur <= S_IDLE;
      cls     <= C_R;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        cls <= dec_cls;
        if (!dec_legal) begin
          halted  <= 1'b1;
          illegal <= !dec_ecall;
        end
      end
    end
  end

  always_comb begin
    nxt       = cur;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src   = 1'b0;
    alu_op    = 2'b00;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    retire    = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run || step) nxt = S_FETCH;
      end
      S_FETCH: begin
        // Gated by rst so a RESET_RUN build keeps the request low while held in reset.
        imem_req = rst;
        if (imem_ready) begin
          ir_we = rst;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt = dec_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_op = 2'b10;
            nxt    = S_WB;
          end
          C_I: begin
            alu_src = 1'b1;
            alu_op  = 2'b11;
            nxt     = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            nxt     = S_MEM;
          end
          C_BRANCH: begin
            alu_op = 2'b01;
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'b01 : 2'b00;
            retire = 1'b1;
            nxt    = run ? S_FETCH : S_IDLE;
          end
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = run ? S_FETCH : S_IDLE;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        pc_we     = 1'b1;
        if (cls == C_LOAD)                        wb_sel = 2'b01;
        else if (cls == C_JAL || cls == C_JALR)   wb_sel = 2'b10;
        if (cls == C_JAL)       pc_sel = 2'b01;
        else if (cls == C_JALR) pc_sel = 2'b10;
        nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

`ifdef STEP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomized bench for cpu_step_ctrl: per-instruction expected output traces built from the instruction class rules.
module tb_cpu_step_ctrl;
  logic       clk, rst, run, step, branch_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, ir_we, dmem_req, dmem_we, reg_write, alu_src, pc_we, retire, halted, illegal;
  logic [1:0] wb_sel, alu_op, pc_sel;
  logic [2:0] state;
`ifdef STEP_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int errors  = 0;
  int checks  = 0;
  int exp_ret = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, dmem_req, dmem_we, reg_write;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       retire, halted, illegal;
  } ov_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_EC = 7, K_BAD = 8;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_EC = 7'b1110011;
  logic [6:0] legal_ops [7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

  ov_t obs;
  assign obs = {state, imem_req, ir_we, dmem_req, dmem_we, reg_write, wb_sel, alu_src, alu_op,
                pc_we, pc_sel, retire, halted, illegal};

  cpu_step_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .step         (step),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .state        (state),
    .retire       (retire),
    .halted       (halted),
    .illegal      (illegal)
`ifdef STEP_PERF_CNT_EN
    ,
    .instret      (instret)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_BR:   return K_BR;
      OP_JAL:  return K_JAL;
      OP_JALR: return K_JALR;
      OP_EC:   return K_EC;
      default: return K_BAD;
    endcase
  endfunction

  function automatic ov_t exp_exec(input int c, input logic bt);
    ov_t e = '0;
    e.st = 3'd3;
    case (c)
      K_R:  e.alu_op = 2'b10;
      K_I:  begin e.alu_src = 1'b1; e.alu_op = 2'b11; end
      K_LD, K_ST: e.alu_src = 1'b1;
      K_BR: begin
        e.alu_op = 2'b01; e.pc_we = 1'b1; e.retire = 1'b1;
        e.pc_sel = bt ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ov_t exp_wb(input int c);
    ov_t e = '0;
    e.st = 3'd5; e.reg_write = 1'b1; e.retire = 1'b1; e.pc_we = 1'b1;
    e.wb_sel = (c == K_LD) ? 2'b01 : ((c == K_JAL || c == K_JALR) ? 2'b10 : 2'b00);
    e.pc_sel = (c == K_JAL) ? 2'b01 : ((c == K_JALR) ? 2'b10 : 2'b00);
    return e;
  endfunction

  // One clock: apply memory handshakes, compare at the falling edge, step past the rising edge.
  task automatic cycle(input string tag, input ov_t e, input logic ir, input logic dr);
    imem_ready = ir;
    dmem_ready = dr;
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(e));
    if (e.retire) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    ov_t e = '0;
    for (int i = 0; i < n; i++) cycle(tag, e, rb(), rb());
  endtask

  // Entered with the DUT in FETCH; run is driven to rl after the fetch completes.
  task automatic do_instr(input logic [6:0] op, input int iw, input int dw, input logic bt, input logic rl);
    ov_t e;
    int  c = cls_of(op);
    opcode = op;
    branch_taken = rb();
    for (int i = 0; i < iw; i++) begin
      step = rb();
      e = '0; e.st = 3'd1; e.imem_req = 1'b1;
      cycle("fetch_wait", e, 1'b0, rb());
    end
    step = rb();
    e = '0; e.st = 3'd1; e.imem_req = 1'b1; e.ir_we = 1'b1;
    cycle("fetch_rdy", e, 1'b1, rb());
    run = rl;
    step = rb();
    e = '0; e.st = 3'd2;
    cycle("decode", e, rb(), rb());
    branch_taken = bt;
    step = rb();
    cycle("exec", exp_exec(c, bt), rb(), rb());
    branch_taken = rb();
    if (c == K_LD || c == K_ST) begin
      for (int i = 0; i <= dw; i++) begin
        step = rb();
        e = '0; e.st = 3'd4; e.dmem_req = 1'b1; e.dmem_we = (c == K_ST);
        if (i == dw && c == K_ST) begin e.pc_we = 1'b1; e.retire = 1'b1; end
        cycle("mem", e, rb(), (i == dw));
      end
    end
    if (c != K_BR && c != K_ST) begin
      step = rb();
      cycle("wb", exp_wb(c), rb(), rb());
    end
    step = 1'b0;
  endtask

  task automatic halt_test(input logic [6:0] op, input logic ill);
    ov_t e;
    run = 1'b1; step = 1'b0;
    idle_cycles("idle_go", 1);
    opcode = op;
    e = '0; e.st = 3'd1; e.imem_req = 1'b1; e.ir_we = 1'b1;
    cycle("h_fetch", e, 1'b1, 1'b0);
    e = '0; e.st = 3'd2;
    cycle("h_decode", e, rb(), rb());
    for (int i = 0; i < 20; i++) begin
      run = rb(); step = rb();
      e = '0; e.st = 3'd6; e.halted = 1'b1; e.illegal = ill;
      cycle("halt", e, rb(), rb());
    end
    run = 1'b0; step = 1'b0;
    #2 rst = 1'b0;
    #1 check_eq("halt_rst", 32'(obs), 32'd0);
    exp_ret = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ov_t e;
    logic [6:0] bad;
    logic rl;
    rst = 1'b0; run = 1'b0; step = 1'b0; opcode = '0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #12 check_eq("reset", 32'(obs), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles("idle_hold", 3);

    // Free-run directed: R, R, delayed load, taken/untaken branch, then drop run.
    run = 1'b1;
    idle_cycles("idle_go", 1);
    do_instr(OP_R, 0, 0, 1'b0, 1'b1);
    do_instr(OP_R, 0, 0, 1'b0, 1'b1);
    do_instr(OP_LD, 0, 3, 1'b0, 1'b1);
    do_instr(OP_BR, 0, 0, 1'b1, 1'b1);
    do_instr(OP_BR, 0, 0, 1'b0, 1'b0);
    idle_cycles("idle_after_run", 2);

    // Single step with jal.
    step = 1'b1;
    idle_cycles("idle_step", 1);
    do_instr(OP_JAL, 0, 0, 1'b0, 1'b0);
    idle_cycles("idle_after_step", 10);

    // Random instruction mix with wait states and occasional run drops.
    run = 1'b1;
    idle_cycles("idle_go", 1);
    for (int k = 0; k < 40; k++) begin
      rl = (k == 39) ? 1'b0 : ($urandom_range(3, 0) != 0);
      do_instr(legal_ops[$urandom_range(6, 0)], $urandom_range(3, 0), $urandom_range(3, 0), rb(), rl);
      if (!rl && k != 39) begin
        idle_cycles("idle_gap", $urandom_range(2, 1));
        run = 1'b1;
        idle_cycles("idle_go", 1);
      end
    end
    idle_cycles("idle_end", 2);
`ifdef STEP_PERF_CNT_EN
    check_eq("instret", instret, 32'(exp_ret));
`endif

    // Reset in the middle of a store's memory phase.
    run = 1'b1;
    idle_cycles("idle_go", 1);
    opcode = OP_ST;
    e = '0; e.st = 3'd1; e.imem_req = 1'b1; e.ir_we = 1'b1;
    cycle("st_fetch", e, 1'b1, 1'b0);
    e = '0; e.st = 3'd2;
    cycle("st_decode", e, 1'b0, 1'b0);
    cycle("st_exec", exp_exec(K_ST, 1'b0), 1'b0, 1'b0);
    dmem_ready = 1'b0;
    #2 check_eq("mem_req_pre", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1 check_eq("mem_req_rst", 32'(dmem_req), 32'd0);
    check_eq("state_rst", 32'(state), 32'd0);
`ifdef STEP_PERF_CNT_EN
    check_eq("instret_rst", instret, 32'd0);
`endif
    exp_ret = 0;
    run = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    halt_test(7'b0000000, 1'b1);
    halt_test(OP_EC, 1'b0);
    bad = 7'b0000000;
    while (cls_of(bad) != K_BAD || bad == 7'b0000000) bad = 7'($urandom_range(127, 0));
    halt_test(bad, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
